timer_mc: RTL and testbench
===========================

Name: timer_mc

Overview:
- Parametrised multi-channel general-purpose timer; next generation of the single-channel SoC timer.
- Adds per-channel prescaler, auto-reload / single-shot modes, per-channel interrupt enable and a common memory-mapped register window.
- Sits on the SoC peripheral data bus; irq outputs go to the core interrupt controller.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..8)
- CNT_WIDTH, 32, counter/compare width in bits (8..32); register bits above CNT_WIDTH read 0
- PSC_WIDTH, 16, prescaler width in bits (1..32)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  1  bus request
- gnt  out  1  bus grant; combinational, equals req
- we  in  1  write enable
- addr  in  12  byte address within the peripheral window
- wdata  in  32  write data
- rvalid  out  1  read/write response valid, one cycle after an accepted req
- rdata  out  32  read data, valid with rvalid
- irq  out  NUM_CH  per-channel interrupt, registered
- cap_in  in  NUM_CH  capture strobes (TIMER_MC_CAPTURE_EN only)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all registers 0; rvalid=0, rdata=0, irq=0; all channels STOPPED.
- Channel n base = n*0x20. Offsets: CR 0x00, SR 0x04, CNTR 0x08, CMPR 0x0C, PSCR 0x10, CAPR 0x14.
- CR bits: [0] trg (write-1 pulse, reads 0), [1] hlt, [2] sngl, [3] ie.
- SR bits: [0] mtch (write-1-to-clear), [1] act (read-only).
- Unmapped, or channel index >= NUM_CH: writes ignored, reads return 0, rvalid still asserted.
- Bus timing: gnt=req. Accepted access gives rvalid=1 on the next cycle. Register writes take effect on the accept edge.
- Channel FSM:
  - STOPPED -> RUNNING on trg=1: cnt<=0, psc_cnt<=0.
  - trg while RUNNING restarts the same way.
  - act=1 iff RUNNING.
- Prescaler, while RUNNING and hlt=0:
  - if psc_cnt==PSCR: tick=1, psc_cnt<=0
  - else psc_cnt<=psc_cnt+1
  - PSCR=0 gives a tick every cycle.
- hlt=1 freezes both cnt and psc_cnt; the channel stays RUNNING.
- On tick:
  - if cnt==CMPR: cnt<=0, mtch<=1; if sngl=1, FSM -> STOPPED.
  - else cnt<=cnt+1.
  - Period = (PSCR+1)*(CMPR+1) cycles. CMPR=0 matches every tick.
  - Counter arithmetic is modulo 2^CNT_WIDTH.
- SW write to CNTR wins over a same-cycle tick update.
- Hardware mtch set wins over a same-cycle SW clear.
- Writing CMPR below the current cnt: no match until wrap at 2^CNT_WIDTH.
- irq[n] <= mtch[n] & ie[n], one cycle after mtch rises.
- rst mid-count: channel returns to STOPPED, all state zeroed on the next edge.

Optional Feature:
- Macro: TIMER_MC_CAPTURE_EN.
- Enabled: rising edge of cap_in[n], detected from a registered previous value, latches cnt into CAPR[n] and sets SR[2] capf (write-1-to-clear).
  - irq also fires on capf & ie.
  - Capture on the same edge as a tick latches the pre-increment value.
- Disabled: no capture logic; cap_in ignored; CAPR and SR[2] read 0.

Test Plan:
- Reset, then read every register of ch0..NUM_CH-1 -> all 0; irq=0; rvalid=1 exactly one cycle after each req.
- ch0: PSCR=0, CMPR=4, CR=trg|ie -> cnt reads 0,1,2,3,4,0; mtch set on the 5th tick; irq high the cycle after. Write SR=1 -> mtch and irq clear.
- ch1: PSCR=2, CMPR=3, sngl=1, trg -> mtch after 12 cycles; act drops to 0; cnt stays 0.
- ch2: running with CMPR=100; set hlt at cnt=10, wait 50 cycles -> cnt=10; clear hlt -> counting resumes at 11.
- Same-cycle conflicts: SW writes CNTR=7 during a tick -> reads 7. SW clears mtch on a match cycle -> mtch stays 1. Access at addr 0x0C0 with NUM_CH=4 -> rdata 0, no side effect.
- TIMER_MC_CAPTURE_EN: ch3 free-running, PSCR=0; pulse cap_in[3] when cnt=0x20 -> CAPR=0x20, capf=1, irq[3]=1 with ie set.

Source files
------------

// File: rtl/timer_mc.sv
// -----------------------------------------------------------------------------
// timer_mc -- multi-channel general-purpose timer with a memory-mapped
// register window on the peripheral data bus.
//
// Each channel has a prescaler, an up-counter with compare/auto-reload,
// single-shot mode, a sticky match flag and a registered interrupt output.
// Channel n occupies addresses n*0x20 .. n*0x20+0x1F:
//   0x00 CR   [0] trg (write-1 pulse, reads 0) [1] hlt [2] sngl [3] ie
//   0x04 SR   [0] mtch (W1C) [1] act (RO) [2] capf (W1C, capture build only)
//   0x08 CNTR counter value
//   0x0C CMPR compare value
//   0x10 PSCR prescaler reload value
//   0x14 CAPR captured counter value (capture build only)
//
// Optional feature macro: TIMER_MC_CAPTURE_EN
//   defined   -> rising edge of cap_in[n] latches the counter into CAPR[n]
//                and sets capf; capf & ie also raises irq[n].
//   undefined -> cap_in is ignored, CAPR and SR[2] read 0.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   req     in   bus request
//   gnt     out  bus grant, combinational copy of req
//   we      in   write enable
//   addr    in   [11:0] byte address within the window
//   wdata   in   [31:0] write data
//   rvalid  out  response valid, one cycle after an accepted request
//   rdata   out  [31:0] read data, valid with rvalid (0 for writes)
//   irq     out  [NUM_CH-1:0] per-channel interrupt, registered
//   cap_in  in   [NUM_CH-1:0] capture strobes
// -----------------------------------------------------------------------------
module timer_mc #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              gnt,
  input  logic              we,
  input  logic [11:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  input  logic [NUM_CH-1:0] cap_in
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [PSC_WIDTH-1:0] PSC_ONE  = PSC_WIDTH'(1);
  localparam logic [PSC_WIDTH-1:0] PSC_ZERO = {PSC_WIDTH{1'b0}};

  // Channel state
  state_t               state_q   [NUM_CH];
  logic [NUM_CH-1:0]    hlt_q;
  logic [NUM_CH-1:0]    sngl_q;
  logic [NUM_CH-1:0]    ie_q;
  logic [NUM_CH-1:0]    mtch_q;
  logic [CNT_WIDTH-1:0] cnt_q     [NUM_CH];
  logic [CNT_WIDTH-1:0] cmp_q     [NUM_CH];
  logic [PSC_WIDTH-1:0] psc_q     [NUM_CH];
  logic [PSC_WIDTH-1:0] psc_cnt_q [NUM_CH];

  // Bus response and interrupt registers
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic [NUM_CH-1:0]    irq_q;

  // Decode and datapath helpers
  logic                 acc_wr_s;
  logic                 acc_rd_s;
  logic [NUM_CH-1:0]    hit_s;
  logic [NUM_CH-1:0]    wr_cr_s;
  logic [NUM_CH-1:0]    wr_sr_s;
  logic [NUM_CH-1:0]    wr_cnt_s;
  logic [NUM_CH-1:0]    wr_cmp_s;
  logic [NUM_CH-1:0]    wr_psc_s;
  logic [NUM_CH-1:0]    tick_s;
  logic [NUM_CH-1:0]    match_s;
  logic [31:0]          ch_rd_s   [NUM_CH];
  logic [31:0]          rd_val_s;

  // Capture view seen by the read mux and the interrupt logic
  logic [NUM_CH-1:0]    capf_s;
  logic [CNT_WIDTH-1:0] capr_s    [NUM_CH];

  assign gnt      = req;
  assign acc_wr_s = req & we;
  assign acc_rd_s = req & ~we;

  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign irq      = irq_q;

  // Address decode, prescaler tick and compare match per channel.
  // Channel indices >= NUM_CH never hit, so those accesses fall through.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      hit_s[c]    = (addr[11:5] == 7'(c));
      wr_cr_s[c]  = acc_wr_s & hit_s[c] & (addr[4:0] == 5'h00);
      wr_sr_s[c]  = acc_wr_s & hit_s[c] & (addr[4:0] == 5'h04);
      wr_cnt_s[c] = acc_wr_s & hit_s[c] & (addr[4:0] == 5'h08);
      wr_cmp_s[c] = acc_wr_s & hit_s[c] & (addr[4:0] == 5'h0C);
      wr_psc_s[c] = acc_wr_s & hit_s[c] & (addr[4:0] == 5'h10);
      tick_s[c]   = (state_q[c] == ST_RUNNING) & ~hlt_q[c] &
                    (psc_cnt_q[c] == psc_q[c]);
      match_s[c]  = tick_s[c] & (cnt_q[c] == cmp_q[c]);
    end
  end

  // Read mux: each channel builds its register value, only the addressed
  // channel is OR-ed into the response.
  always_comb begin
    rd_val_s = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_rd_s[c] = 32'd0;
      case (addr[4:0])
        5'h00:   ch_rd_s[c][3:0] = {ie_q[c], sngl_q[c], hlt_q[c], 1'b0};
        5'h04:   ch_rd_s[c][2:0] = {capf_s[c], (state_q[c] == ST_RUNNING), mtch_q[c]};
        5'h08:   ch_rd_s[c][CNT_WIDTH-1:0] = cnt_q[c];
        5'h0C:   ch_rd_s[c][CNT_WIDTH-1:0] = cmp_q[c];
        5'h10:   ch_rd_s[c][PSC_WIDTH-1:0] = psc_q[c];
        5'h14:   ch_rd_s[c][CNT_WIDTH-1:0] = capr_s[c];
        default: ch_rd_s[c] = 32'd0;
      endcase
      rd_val_s = rd_val_s | (ch_rd_s[c] & {32{acc_rd_s & hit_s[c]}});
    end
  end

  // Channel FSMs, counters, software-visible registers and bus response.
  // Later assignments win: trg restart over tick, SW CNTR write over tick,
  // hardware match set over SW mtch clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      irq_q    <= {NUM_CH{1'b0}};
      hlt_q    <= {NUM_CH{1'b0}};
      sngl_q   <= {NUM_CH{1'b0}};
      ie_q     <= {NUM_CH{1'b0}};
      mtch_q   <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= ST_STOPPED;
        cnt_q[c]     <= CNT_ZERO;
        cmp_q[c]     <= CNT_ZERO;
        psc_q[c]     <= PSC_ZERO;
        psc_cnt_q[c] <= PSC_ZERO;
      end
    end else begin
      rvalid_q <= req;
      rdata_q  <= rd_val_s;
      for (int c = 0; c < NUM_CH; c++) begin
        irq_q[c] <= ie_q[c] & (mtch_q[c] | capf_s[c]);

        if ((state_q[c] == ST_RUNNING) && !hlt_q[c]) begin
          if (tick_s[c]) begin
            psc_cnt_q[c] <= PSC_ZERO;
            if (match_s[c]) begin
              cnt_q[c] <= CNT_ZERO;
              if (sngl_q[c]) begin
                state_q[c] <= ST_STOPPED;
              end
            end else begin
              cnt_q[c] <= cnt_q[c] + CNT_ONE;
            end
          end else begin
            psc_cnt_q[c] <= psc_cnt_q[c] + PSC_ONE;
          end
        end

        if (wr_cr_s[c]) begin
          hlt_q[c]  <= wdata[1];
          sngl_q[c] <= wdata[2];
          ie_q[c]   <= wdata[3];
          if (wdata[0]) begin
            state_q[c]   <= ST_RUNNING;
            cnt_q[c]     <= CNT_ZERO;
            psc_cnt_q[c] <= PSC_ZERO;
          end
        end

        if (wr_cnt_s[c]) begin
          cnt_q[c] <= wdata[CNT_WIDTH-1:0];
        end
        if (wr_cmp_s[c]) begin
          cmp_q[c] <= wdata[CNT_WIDTH-1:0];
        end
        if (wr_psc_s[c]) begin
          psc_q[c] <= wdata[PSC_WIDTH-1:0];
        end

        if (wr_sr_s[c] && wdata[0]) begin
          mtch_q[c] <= 1'b0;
        end
        if (match_s[c]) begin
          mtch_q[c] <= 1'b1;
        end
      end
    end
  end

`ifdef TIMER_MC_CAPTURE_EN
  logic [NUM_CH-1:0]    cap_prev_q;
  logic [NUM_CH-1:0]    capf_q;
  logic [CNT_WIDTH-1:0] capr_q [NUM_CH];
  logic [NUM_CH-1:0]    cap_rise_s;

  // Rising-edge detect against the previous strobe value; expose capture regs.
  always_comb begin
    cap_rise_s = cap_in & ~cap_prev_q;
    capf_s     = capf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      capr_s[c] = capr_q[c];
    end
  end

  // Capture registers; cnt_q is sampled before this edge's tick update,
  // so a capture coinciding with a tick latches the pre-increment value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_prev_q <= {NUM_CH{1'b0}};
      capf_q     <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        capr_q[c] <= CNT_ZERO;
      end
    end else begin
      cap_prev_q <= cap_in;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_rise_s[c]) begin
          capr_q[c] <= cnt_q[c];
        end
        if (wr_sr_s[c] && wdata[2]) begin
          capf_q[c] <= 1'b0;
        end
        if (cap_rise_s[c]) begin
          capf_q[c] <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_cap_s;

  assign unused_cap_s = ^cap_in;

  // Without capture support the capture view is constant zero.
  always_comb begin
    capf_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      capr_s[c] = CNT_ZERO;
    end
  end
`endif

endmodule

// File: tb/tb_timer_mc.sv
// -----------------------------------------------------------------------------
// tb_timer_mc -- directed self-checking bench for timer_mc (NUM_CH=4,
// CNT_WIDTH=32, PSC_WIDTH=16). Inputs change on the falling clock edge,
// outputs are sampled 1 time unit after the rising edge.
// Expected capture results depend on TIMER_MC_CAPTURE_EN.
// -----------------------------------------------------------------------------
module tb_timer_mc;

  localparam int NUM_CH = 4;

`ifdef TIMER_MC_CAPTURE_EN
  localparam logic CAPEN = 1'b1;
`else
  localparam logic CAPEN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              gnt;
  logic              we;
  logic [11:0]       addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] irq;
  logic [NUM_CH-1:0] cap_in;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] r;

  timer_mc #(
    .NUM_CH   (NUM_CH),
    .CNT_WIDTH(32),
    .PSC_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rvalid(rvalid),
    .rdata (rdata),
    .irq   (irq),
    .cap_in(cap_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus access: request during the low phase, accepted on the next
  // rising edge, response sampled just after that edge.
  task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    #1;
    chk("gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    rd  = rdata;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    bus(1'b0, a, 32'd0, v);
  endtask

  initial begin
    rst    = 1'b1;
    req    = 1'b0;
    we     = 1'b0;
    addr   = 12'h000;
    wdata  = 32'd0;
    cap_in = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_irq", {28'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int o = 0; o < 6; o++) begin
        rd(12'(ch * 32 + o * 4), r);
        chk("rst_reg", r, 32'd0);
      end
    end

    // ch0: PSCR=0, CMPR=4, trg|ie -> 0,1,2,3,4,0
    wr(12'h010, 32'd0);
    wr(12'h00C, 32'd4);
    wr(12'h000, 32'h9);
    for (int k = 0; k < 5; k++) begin
      rd(12'h008, r);
      chk("ch0_cnt", r, 32'(k));
    end
    chk("ch0_irq_before", {31'd0, irq[0]}, 32'd0);
    rd(12'h008, r);
    chk("ch0_cnt_wrap", r, 32'd0);
    chk("ch0_irq_after", {31'd0, irq[0]}, 32'd1);
    rd(12'h004, r);
    chk("ch0_sr_mtch", r, 32'h3);
    wr(12'h004, 32'h1);
    rd(12'h004, r);
    chk("ch0_sr_clr", r, 32'h2);
    chk("ch0_irq_clr", {31'd0, irq[0]}, 32'd0);

    // ch1: PSCR=2, CMPR=3, single-shot -> match after 12 cycles, stops
    wr(12'h030, 32'd2);
    wr(12'h02C, 32'd3);
    wr(12'h020, 32'h5);
    for (int k = 1; k <= 12; k++) begin
      rd(12'h024, r);
      chk("ch1_sr_run", r, 32'h2);
    end
    rd(12'h024, r);
    chk("ch1_sr_done", r, 32'h1);
    rd(12'h028, r);
    chk("ch1_cnt_stop", r, 32'd0);

    // ch2: CMPR=100, halt at cnt=10 for 50 cycles, then resume
    wr(12'h050, 32'd0);
    wr(12'h04C, 32'd100);
    wr(12'h040, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      rd(12'h048, r);
      chk("ch2_cnt", r, 32'(k - 1));
    end
    wr(12'h040, 32'h2);
    repeat (50) @(posedge clk);
    rd(12'h048, r);
    chk("ch2_hlt_cnt", r, 32'd10);
    rd(12'h044, r);
    chk("ch2_hlt_act", r, 32'h2);
    wr(12'h040, 32'h0);
    rd(12'h048, r);
    chk("ch2_resume0", r, 32'd10);
    rd(12'h048, r);
    chk("ch2_resume1", r, 32'd11);

    // SW write to CNTR on a tick edge wins; CMPR below cnt gives no wrap
    wr(12'h008, 32'd7);
    rd(12'h008, r);
    chk("ch0_cntr_wr", r, 32'd7);
    rd(12'h008, r);
    chk("ch0_cntr_next", r, 32'd8);

    // ch3: CMPR=2, SW clear of mtch on a match edge loses
    wr(12'h070, 32'd0);
    wr(12'h06C, 32'd2);
    wr(12'h060, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      rd(12'h068, r);
      chk("ch3_cnt", r, 32'((k - 1) % 3));
    end
    wr(12'h064, 32'h1);
    rd(12'h064, r);
    chk("ch3_clr_conflict", r, 32'h3);
    wr(12'h064, 32'h1);
    rd(12'h064, r);
    chk("ch3_clr_plain", r, 32'h2);

    // Out-of-range channel and unmapped offset
    wr(12'h0C0, 32'hE);
    rd(12'h0C0, r);
    chk("unmapped_rd", r, 32'd0);
    rd(12'h040, r);
    chk("unmapped_alias", r, 32'd0);
    rd(12'h018, r);
    chk("unmapped_off", r, 32'd0);

    // Capture on ch3 at cnt=0x20
    wr(12'h06C, 32'h0000FFFF);
    wr(12'h064, 32'h1);
    wr(12'h060, 32'h9);
    repeat (32) @(posedge clk);
    @(negedge clk);
    cap_in = 4'b1000;
    @(posedge clk);
    #1;
    cap_in = 4'b0000;
    rd(12'h074, r);
    chk("cap_capr", r, CAPEN ? 32'h20 : 32'd0);
    rd(12'h064, r);
    chk("cap_sr", r, CAPEN ? 32'h6 : 32'h2);
    chk("cap_irq", {31'd0, irq[3]}, {31'd0, CAPEN});

    // No request -> no response
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("idle_rvalid", {31'd0, rvalid}, 32'd0);

    // Reset mid-count
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_irq", {28'd0, irq}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    rd(12'h008, r);
    chk("mid_rst_cnt0", r, 32'd0);
    rd(12'h004, r);
    chk("mid_rst_sr0", r, 32'd0);
    rd(12'h064, r);
    chk("mid_rst_sr3", r, 32'd0);
    rd(12'h048, r);
    chk("mid_rst_cnt2", r, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
